// File: rtl/cache_bus1_responder_if.sv
// Bus-1 responder port bundle: CPU-side split tri-state bus plus the cache-core
// request/ack handshake. "slave" is the responder view, "master" the CPU/core view.
interface cache_bus1_responder_if #(
  parameter int TAGSET_W = 15,
  parameter int OFFSET_W = 4,
  parameter int DATA_W   = 16,
  parameter int CTR_W    = 3
);
  logic [TAGSET_W-1:0] a1_in;
  logic [DATA_W-1:0]   d1_in;
  logic [CTR_W-1:0]    c1_in;
  logic [DATA_W-1:0]   d1_out;
  logic                d1_oe;
  logic [CTR_W-1:0]    c1_out;
  logic                c1_oe;
  logic                core_req;
  logic [CTR_W-1:0]    core_op;
  logic [TAGSET_W-1:0] core_tagset;
  logic [OFFSET_W-1:0] core_offset;
  logic [31:0]         core_wdata;
  logic                core_ack;
  logic [31:0]         core_rdata;
  logic                busy;

  modport slave (
    input  a1_in, d1_in, c1_in, core_ack, core_rdata,
    output d1_out, d1_oe, c1_out, c1_oe, core_req, core_op,
           core_tagset, core_offset, core_wdata, busy
  );

  modport master (
    output a1_in, d1_in, c1_in, core_ack, core_rdata,
    input  d1_out, d1_oe, c1_out, c1_oe, core_req, core_op,
           core_tagset, core_offset, core_wdata, busy
  );
endinterface

// File: rtl/cache_bus1_responder.sv
// Cache-side bus-1 responder: decodes the two-beat CPU command, runs one core
// request, drives the RESPONSE beat(s) and hands the bus back to the CPU.
module cache_bus1_responder #(
  parameter int TAGSET_W = 15,
  parameter int OFFSET_W = 4,
  parameter int DATA_W   = 16,
  parameter int CTR_W    = 3
) (
  input logic clk,
  input logic rst_n,
  cache_bus1_responder_if.slave bus
);

  localparam logic [CTR_W-1:0] OP_NOP      = CTR_W'(3'd0);
  localparam logic [CTR_W-1:0] OP_READ8    = CTR_W'(3'd1);
  localparam logic [CTR_W-1:0] OP_READ16   = CTR_W'(3'd2);
  localparam logic [CTR_W-1:0] OP_READ32   = CTR_W'(3'd3);
  localparam logic [CTR_W-1:0] OP_INV_LINE = CTR_W'(3'd4);
  localparam logic [CTR_W-1:0] OP_WRITE8   = CTR_W'(3'd5);
  localparam logic [CTR_W-1:0] OP_WRITE16  = CTR_W'(3'd6);
  localparam logic [CTR_W-1:0] OP_WRITE32  = CTR_W'(3'd7);
  localparam logic [CTR_W-1:0] OP_RESPONSE = CTR_W'(3'd7);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR2 = 3'd1,
    ST_TURN  = 3'd2,
    ST_OWN   = 3'd3,
    ST_RESP1 = 3'd4,
    ST_RESP2 = 3'd5,
    ST_REL   = 3'd6
  } state_t;

  state_t              state_r, state_next_s;
  logic [CTR_W-1:0]    op_r, op_next_s;
  logic [TAGSET_W-1:0] tagset_r, tagset_next_s;
  logic [OFFSET_W-1:0] offset_r, offset_next_s;
  logic [31:0]         wdata_r, wdata_next_s;
  logic [31:0]         rdata_r, rdata_next_s;

  logic                c1_oe_r, c1_oe_next_s;
  logic [CTR_W-1:0]    c1_out_r, c1_out_next_s;
  logic                d1_oe_r, d1_oe_next_s;
  logic [DATA_W-1:0]   d1_out_r, d1_out_next_s;
  logic                req_r, req_next_s;
  logic                busy_r, busy_next_s;

  // Next-state and latch-update logic for the command/response sequence
  always_comb begin
    state_next_s  = state_r;
    op_next_s     = op_r;
    tagset_next_s = tagset_r;
    offset_next_s = offset_r;
    wdata_next_s  = wdata_r;
    rdata_next_s  = rdata_r;
    case (state_r)
      ST_IDLE: begin
        // Case-inequality so an X/Z command still starts a transaction
        if (bus.c1_in !== OP_NOP) begin
          op_next_s     = bus.c1_in;
          tagset_next_s = bus.a1_in;
          case (bus.c1_in)
            OP_WRITE8:              wdata_next_s = {24'd0, bus.d1_in[7:0]};
            OP_WRITE16, OP_WRITE32: wdata_next_s = 32'(bus.d1_in);
            default:                wdata_next_s = wdata_r;
          endcase
          if (bus.c1_in == OP_INV_LINE) begin
            state_next_s = ST_TURN;
          end else begin
            state_next_s = ST_ADDR2;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ADDR2: begin
        offset_next_s = bus.a1_in[OFFSET_W-1:0];
        if (op_r == OP_WRITE32) begin
          wdata_next_s = {16'(bus.d1_in), wdata_r[15:0]};
        end else begin
          wdata_next_s = wdata_r;
        end
        state_next_s = ST_TURN;
      end
      ST_TURN: state_next_s = ST_OWN;
      ST_OWN: begin
        if (bus.core_ack) begin
          rdata_next_s = bus.core_rdata;
          state_next_s = ST_RESP1;
        end else begin
          state_next_s = ST_OWN;
        end
      end
      ST_RESP1: begin
        if (op_r == OP_READ32) begin
          state_next_s = ST_RESP2;
        end else begin
          state_next_s = ST_REL;
        end
      end
      ST_RESP2: state_next_s = ST_REL;
      ST_REL:   state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop
  always_comb begin
    c1_oe_next_s  = 1'b0;
    c1_out_next_s = OP_NOP;
    d1_oe_next_s  = 1'b0;
    d1_out_next_s = '0;
    req_next_s    = 1'b0;
    busy_next_s   = (state_next_s != ST_IDLE);
    case (state_next_s)
      ST_OWN: begin
        c1_oe_next_s = 1'b1;
        req_next_s   = 1'b1;
      end
      ST_RESP1: begin
        c1_oe_next_s  = 1'b1;
        c1_out_next_s = OP_RESPONSE;
        case (op_next_s)
          OP_READ8: begin
            d1_oe_next_s  = 1'b1;
            d1_out_next_s = DATA_W'(rdata_next_s[7:0]);
          end
          OP_READ16, OP_READ32: begin
            d1_oe_next_s  = 1'b1;
            d1_out_next_s = DATA_W'(rdata_next_s[15:0]);
          end
          default: begin
            d1_oe_next_s  = 1'b0;
            d1_out_next_s = '0;
          end
        endcase
      end
      ST_RESP2: begin
        c1_oe_next_s  = 1'b1;
        c1_out_next_s = OP_RESPONSE;
        d1_oe_next_s  = 1'b1;
        d1_out_next_s = DATA_W'(rdata_next_s[31:16]);
      end
      default: begin
        c1_oe_next_s = 1'b0;
        req_next_s   = 1'b0;
      end
    endcase
  end

  // State, latched request fields and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      op_r     <= '0;
      tagset_r <= '0;
      offset_r <= '0;
      wdata_r  <= 32'd0;
      rdata_r  <= 32'd0;
      c1_oe_r  <= 1'b0;
      c1_out_r <= OP_NOP;
      d1_oe_r  <= 1'b0;
      d1_out_r <= '0;
      req_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      op_r     <= op_next_s;
      tagset_r <= tagset_next_s;
      offset_r <= offset_next_s;
      wdata_r  <= wdata_next_s;
      rdata_r  <= rdata_next_s;
      c1_oe_r  <= c1_oe_next_s;
      c1_out_r <= c1_out_next_s;
      d1_oe_r  <= d1_oe_next_s;
      d1_out_r <= d1_out_next_s;
      req_r    <= req_next_s;
      busy_r   <= busy_next_s;
    end
  end

  assign bus.c1_oe       = c1_oe_r;
  assign bus.c1_out      = c1_out_r;
  assign bus.d1_oe       = d1_oe_r;
  assign bus.d1_out      = d1_out_r;
  assign bus.core_req    = req_r;
  assign bus.core_op     = op_r;
  assign bus.core_tagset = tagset_r;
  assign bus.core_offset = offset_r;
  assign bus.core_wdata  = wdata_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_cache_bus1_responder.sv
// Directed bench for cache_bus1_responder: a table of complete bus transactions
// checked cycle by cycle against spec latencies, plus reset/robustness sequences.
module tb_cache_bus1_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  cache_bus1_responder_if #(.TAGSET_W(15), .OFFSET_W(4), .DATA_W(16), .CTR_W(3)) bus ();

  cache_bus1_responder #(.TAGSET_W(15), .OFFSET_W(4), .DATA_W(16), .CTR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [14:0] tagset;
    logic [3:0]  offset;
    logic [15:0] beat1;
    logic [15:0] beat2;
    int          wait_cyc;
    logic [31:0] rdata;
    bit          inject;
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_offset;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [22:0] outs();
    return {bus.busy, bus.core_req, bus.c1_oe, bus.c1_out, bus.d1_oe, bus.d1_out};
  endfunction

  // One full transaction; command presented in the current cycle (cycle 0).
  task automatic run_txn(input vec_t v, input string name);
    bit is_inv, is_r32, is_read;
    int own_start, ack_c, last_resp, rel_c;
    logic exp_busy, exp_req, exp_c1oe, exp_d1oe, in_r1, in_r2;
    logic [2:0] exp_c1;
    logic [15:0] exp_d1;
    is_inv    = (v.op == 3'd4);
    is_r32    = (v.op == 3'd3);
    is_read   = (v.op >= 3'd1) && (v.op <= 3'd3);
    own_start = is_inv ? 2 : 3;
    ack_c     = own_start + v.wait_cyc;
    last_resp = is_r32 ? ack_c + 2 : ack_c + 1;
    rel_c     = last_resp + 1;
    bus.c1_in      = v.op;
    bus.a1_in      = v.tagset;
    bus.d1_in      = v.beat1;
    bus.core_ack   = 1'b0;
    bus.core_rdata = v.rdata;
    for (int c = 1; c <= rel_c + 1; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        bus.c1_in = 3'd0;
        bus.a1_in = 15'(v.offset);
        bus.d1_in = v.beat2;
      end else if (v.inject && c >= own_start && c <= ack_c) begin
        bus.c1_in = 3'd2;
        bus.a1_in = 15'h1111;
        bus.d1_in = 16'h2222;
      end else begin
        bus.c1_in = 3'd0;
        bus.a1_in = 15'd0;
        bus.d1_in = 16'd0;
      end
      bus.core_ack = (c == ack_c);
      in_r1    = (c == ack_c + 1);
      in_r2    = is_r32 && (c == ack_c + 2);
      exp_busy = (c <= rel_c);
      exp_req  = (c >= own_start) && (c <= ack_c);
      exp_c1oe = (c >= own_start) && (c <= last_resp);
      exp_c1   = (in_r1 || in_r2) ? 3'd7 : 3'd0;
      exp_d1oe = (in_r1 && is_read) || in_r2;
      exp_d1   = (in_r1 && is_read) ? v.exp_lo : (in_r2 ? v.exp_hi : 16'd0);
      check($sformatf("%s_cyc%0d", name, c), 64'(outs()),
            64'({exp_busy, exp_req, exp_c1oe, exp_c1, exp_d1oe, exp_d1}));
    end
    bus.core_ack = 1'b0;
    check({name, "_op"},     64'(bus.core_op),     64'(v.op));
    check({name, "_tagset"}, 64'(bus.core_tagset), 64'(v.tagset));
    check({name, "_offset"}, 64'(bus.core_offset), 64'(v.exp_offset));
    check({name, "_wdata"},  64'(bus.core_wdata),  64'(v.exp_wdata));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t w8;
    //          op    tagset    off   beat1     beat2     W  rdata          inj  lo        hi        wdata          off
    vecs[0] = '{3'd1, 15'h1234, 4'd5,  16'h0000, 16'h0000, 0, 32'hDEADBEEF, 1'b0, 16'h00EF, 16'h0000, 32'h00000000, 4'd5};
    vecs[1] = '{3'd3, 15'h0ABC, 4'd8,  16'h0000, 16'h0000, 4, 32'h12345678, 1'b1, 16'h5678, 16'h1234, 32'h00000000, 4'd8};
    vecs[2] = '{3'd7, 15'h0F0F, 4'd12, 16'hBEEF, 16'hCAFE, 1, 32'h55555555, 1'b0, 16'h0000, 16'h0000, 32'hCAFEBEEF, 4'd12};
    vecs[3] = '{3'd4, 15'h7FFF, 4'd3,  16'h0000, 16'h0000, 0, 32'h0000FFFF, 1'b0, 16'h0000, 16'h0000, 32'hCAFEBEEF, 4'd12};
    vecs[4] = '{3'd2, 15'h0001, 4'd15, 16'h0000, 16'h0000, 2, 32'hA5A5C3C3, 1'b0, 16'hC3C3, 16'h0000, 32'hCAFEBEEF, 4'd15};
    vecs[5] = '{3'd6, 15'h4000, 4'd0,  16'h9876, 16'hFFFF, 0, 32'h00000000, 1'b0, 16'h0000, 16'h0000, 32'h00009876, 4'd0};
    vecs[6] = '{3'd5, 15'h2AAA, 4'd9,  16'h1234, 16'h0000, 3, 32'h00000000, 1'b0, 16'h0000, 16'h0000, 32'h00000034, 4'd9};
    w8      = '{3'd5, 15'h0055, 4'd7,  16'h01A5, 16'h0000, 1, 32'h0BADF00D, 1'b0, 16'h0000, 16'h0000, 32'h000000A5, 4'd7};

    bus.a1_in = 15'd0; bus.d1_in = 16'd0; bus.c1_in = 3'd0;
    bus.core_ack = 1'b0; bus.core_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", 64'(outs()), 64'd0);
    check("reset_regs", 64'({bus.core_op, bus.core_tagset, bus.core_offset, bus.core_wdata}), 64'd0);
    rst_n = 1'b1;

    // Spurious ack while idle must not start anything
    bus.core_ack = 1'b1;
    bus.core_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("spurious_ack_%0d", i), 64'(outs()), 64'd0);
    end
    bus.core_ack = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted while the responder owns the bus
    bus.c1_in = 3'd6; bus.a1_in = 15'h3333; bus.d1_in = 16'h7777;
    @(posedge clk); #1;
    bus.c1_in = 3'd0; bus.a1_in = 15'd6; bus.d1_in = 16'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("own_before_reset", 64'(outs()), 64'({1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 16'd0}));
    rst_n = 1'b0;
    #1;
    check("midreset_outs", 64'(outs()), 64'd0);
    check("midreset_regs", 64'({bus.core_op, bus.core_tagset, bus.core_offset, bus.core_wdata}), 64'd0);
    @(posedge clk); #1;
    check("midreset_hold", 64'(outs()), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", 64'(outs()), 64'd0);
    run_txn(w8, "write8_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_bus1_responder.md
# cache_bus1_responder

Cache-side responder for the CPU↔L1 bus 1, the counterpart of the CPU initiator. It decodes the CPU command phase (tag+set beat, then offset beat), hands one request to the cache core over a req/ack handshake, and returns the bus-1 response, with read data when the command is a read. It then releases the bus back to the CPU. The shared tri-state bus is modelled as split in/out/output-enable signals; top-level tri-state glue is outside this block.

## Interface
- `TAGSET_W`, default 15: tag+set width, carried on a1 in the first beat.
- `OFFSET_W`, default 4: offset width, carried on a1[OFFSET_W-1:0] in the second beat.
- `DATA_W`, default 16: d1 width.
- `CTR_W`, default 3: c1 width. Codes: NOP=0, READ8=1, READ16=2, READ32=3, INVALIDATE_LINE=4, WRITE8=5, WRITE16=6, WRITE32=7, RESPONSE=7.
- `clk` — in — 1 — single clock; all state changes on the rising edge.
- `rst_n` — in — 1 — asynchronous, active-low reset.
- `a1_in` — in — TAGSET_W — bus-1 address as driven by the CPU.
- `d1_in` — in — DATA_W — bus-1 data as driven by the CPU.
- `c1_in` — in — CTR_W — bus-1 command as driven by the CPU.
- `d1_out` / `d1_oe` — out — DATA_W / 1 — response data and its drive enable.
- `c1_out` / `c1_oe` — out — CTR_W / 1 — responder command and its drive enable.
- `core_req` — out — 1 — request valid to the cache core; held until `core_ack`.
- `core_op` — out — CTR_W — latched command code.
- `core_tagset` — out — TAGSET_W — latched tag+set.
- `core_offset` — out — OFFSET_W — latched offset.
- `core_wdata` — out — 32 — write data: zero-extended for WRITE8/16.
- `core_ack` — in — 1 — one-cycle pulse: core finished; `core_rdata` is valid in the same cycle.
- `core_rdata` — in — 32 — read result.
- `busy` — out — 1 — high in every state except IDLE.

## Operation
- States: IDLE, ADDR2, TURN, OWN, RESP1, RESP2, REL.
- **IDLE** (bus owned by CPU; all `*_oe`=0):
  - On an edge with `c1_in` != NOP (including X/Z), latch `core_op`=c1_in and `core_tagset`=a1_in.
  - For WRITE8, latch wdata = d1_in[7:0].
  - For WRITE16/WRITE32, latch wdata low half = d1_in.
  - Next state: TURN for INVALIDATE_LINE; ADDR2 for every other command.
- **ADDR2**: latch `core_offset`=a1_in[OFFSET_W-1:0].
  - For WRITE32, latch wdata[31:16]=d1_in.
  - Next state: TURN.
- **TURN**: one idle turnaround cycle; no side drives. Next state: OWN.
- **OWN**:
  - Drive `c1_oe`=1, `c1_out`=NOP.
  - Assert `core_req`.
  - On `core_ack`, latch `core_rdata` into the response register and go to RESP1.
  - `core_ack` is ignored in every other state.
- **RESP1**: drive `c1_out`=RESPONSE.
  - Reads: `d1_oe`=1. READ8 drives {8'b0, rdata[7:0]}; READ16 drives rdata[15:0]; READ32 drives rdata[15:0].
  - Writes and INVALIDATE_LINE: `d1_oe`=0.
  - Next state: RESP2 for READ32, otherwise REL.
- **RESP2**: `c1_out`=RESPONSE, `d1_out`=rdata[31:16], `d1_oe`=1. Next state: REL.
- **REL**: all `*_oe`=0 (ownership returns to the CPU). Next state: IDLE. `c1_in` is not sampled in this cycle.
- `c1_in`, `a1_in` and `d1_in` are ignored in states TURN through REL.
- Offsets are forwarded unchanged; alignment is not checked.

## Timing
- Reset: asynchronous. State=IDLE; `c1_oe`=`d1_oe`=0; `c1_out`=NOP; `d1_out`=0; `core_req`=0; all latched registers=0; `busy`=0.
- Reset asserted mid-transaction: the transaction is dropped, `core_req` falls immediately, and no response is issued.
- Outputs are Moore: registered state only.
- Latency, with the first command edge at cycle 0 and `core_ack` first sampled high at cycle 3+W:
  - `core_req` is high from cycle 3 (2 for INVALIDATE_LINE).
  - RESPONSE is driven in cycle 4+W (3+W for INVALIDATE_LINE), plus cycle 5+W for READ32.
  - REL follows the last RESPONSE cycle.
- Minimum spacing between back-to-back CPU commands: a new command is accepted on the first IDLE edge after REL.
- Under reset-free operation, `core_req` is never deasserted before `core_ack`.

## Test plan
- **READ8**: tagset=0x1234, offset=5, core acks at cycle 3 with rdata=0xDEADBEEF → RESPONSE with d1=0x00EF at cycle 4, REL at 5, `core_req` high only in cycle 3.
- **READ32**: core acks after 4 wait cycles with rdata=0x12345678 → d1=0x5678 at cycle 8, d1=0x1234 at cycle 9, `d1_oe` low at cycle 10.
- **WRITE32**: beats d1=0xBEEF then d1=0xCAFE, offset=12 → `core_wdata`=0xCAFEBEEF, `core_offset`=12; RESPONSE with `d1_oe`=0.
- **INVALIDATE_LINE**: tagset=0x7FFF → `core_req` at cycle 2, RESPONSE at 3; `core_offset` unchanged.
- **Robustness**: spurious `core_ack` in IDLE → no effect. `c1_in`=READ16 during OWN → ignored.
- **Reset**: `rst_n` low during OWN → all outputs return to reset values immediately; after release, a fresh WRITE8 of 0x1A5 completes with wdata=0x000000A5.
